// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode and FSM state enums plus flag-bit indices for alu_seq.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MUL  = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operation request / result bundle between a requester and alu_seq.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] ALU_Out;
    logic [WIDTH-1:0] ALU_OutHi;
    logic             CarryOut;
    logic             Zero;
    logic             Negative;
    logic             Overflow;
    logic             OpErr;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, ALU_Out, ALU_OutHi, CarryOut, Zero, Negative, Overflow, OpErr
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, ALU_Out, ALU_OutHi, CarryOut, Zero, Negative, Overflow, OpErr
    );

endinterface

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - unsigned shift-add multiplier, one iteration per step pulse.
// Only instantiated when ALU_SEQ_MUL_EN is defined.
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] product_o
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     partial;

    // Multiplier sits in the low half and is consumed LSB-first as the product shifts in.
    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        partial = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        if (load_i) begin
            mcand_d = a_i;
            prod_d  = {{WIDTH{1'b0}}, b_i};
        end else if (step_i) begin
            prod_d  = {partial, prod_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    assign product_o = prod_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: start/busy/done handshake, registered result and flags.
// Define ALU_SEQ_MUL_EN to compile in the multi-cycle shift-add MUL path.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);

    state_e            state_q;
    op_e               op_q;
    op_e               start_op;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  out_q, hi_q;
    logic [FLAG_W-1:0] flags_q;
    logic              operr_q, busy_q, done_q;

    logic [WIDTH:0]    sum_ext;
    logic [WIDTH-1:0]  ex_out;
    logic [FLAG_W-1:0] ex_flags;
    logic              ex_err;

    assign start_op = op_e'(bus.Op);

    always_comb begin
        sum_ext  = '0;
        ex_out   = '0;
        ex_flags = '0;
        ex_err   = 1'b0;
        case (op_q)
            OP_ADD: begin
                sum_ext          = {1'b0, a_q} + {1'b0, b_q};
                ex_out           = sum_ext[WIDTH-1:0];
                ex_flags[FLAG_C] = sum_ext[WIDTH];
                ex_flags[FLAG_V] = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ex_out[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                sum_ext          = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
                ex_out           = sum_ext[WIDTH-1:0];
                ex_flags[FLAG_C] = sum_ext[WIDTH];
                ex_flags[FLAG_V] = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (ex_out[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: ex_out = a_q & b_q;
            OP_OR:  ex_out = a_q | b_q;
            OP_XOR: ex_out = a_q ^ b_q;
            OP_SHL: begin
                ex_out           = {a_q[WIDTH-2:0], 1'b0};
                ex_flags[FLAG_C] = a_q[WIDTH-1];
            end
            OP_SHR: begin
                ex_out           = {1'b0, a_q[WIDTH-1:1]};
                ex_flags[FLAG_C] = a_q[0];
            end
            // MUL only reaches EXEC when the multiplier is not built in.
            default: ex_err = 1'b1;
        endcase
        ex_flags[FLAG_Z] = !ex_err && (ex_out == '0);
        ex_flags[FLAG_N] = ex_out[WIDTH-1];
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    logic [CW-1:0]      cnt_q;
    logic               mul_load, mul_step;
    logic [2*WIDTH-1:0] product;
    logic [FLAG_W-1:0]  mul_flags;

    assign mul_load = ((state_q == IDLE) || (state_q == DONE)) && bus.Start && (start_op == OP_MUL);
    // WIDTH step cycles, then one more cycle in MUL to register the finished product.
    assign mul_step = (state_q == MUL) && (cnt_q != CNT_LAST);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .load_i    (mul_load),
        .step_i    (mul_step),
        .a_i       (bus.A),
        .b_i       (bus.B),
        .product_o (product)
    );

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_C] = |product[2*WIDTH-1:WIDTH];
        mul_flags[FLAG_Z] = (product == '0);
        mul_flags[FLAG_N] = product[WIDTH-1];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            operr_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            cnt_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.Start) begin
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        op_q   <= start_op;
                        busy_q <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
                        if (start_op == OP_MUL) begin
                            state_q <= MUL;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= EXEC;
                        end
`else
                        state_q <= EXEC;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    out_q   <= ex_out;
                    hi_q    <= '0;
                    flags_q <= ex_flags;
                    operr_q <= ex_err;
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        out_q   <= product[WIDTH-1:0];
                        hi_q    <= product[2*WIDTH-1:WIDTH];
                        flags_q <= mul_flags;
                        operr_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.ALU_Out   = out_q;
    assign bus.ALU_OutHi = hi_q;
    assign bus.CarryOut  = flags_q[FLAG_C];
    assign bus.Zero      = flags_q[FLAG_Z];
    assign bus.Negative  = flags_q[FLAG_N];
    assign bus.Overflow  = flags_q[FLAG_V];
    assign bus.OpErr     = operr_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with an arithmetic reference model.
module tb_alu_seq;

    localparam int     W   = 8;
    localparam longint M   = longint'(1) << W;
    localparam int     TMO = 200;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int     op;
        longint out;
        longint hi;
        int     c, z, n, v, err;
        int     lat;
        int     acc;
    } exp_t;

    exp_t   sb[$];
    exp_t   me;
    int     checks = 0, failures = 0;
    int     cyc = 0, issued = 0, popped = 0, aborted = 0;
    longint last_out = 0;

    always @(posedge clk) cyc++;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic fail(string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", nm);
    endtask

    function automatic longint sgn(longint x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    function automatic exp_t model(int op, longint a, longint b);
        exp_t   e;
        longint r;
        e.op = op; e.out = 0; e.hi = 0; e.c = 0; e.z = 0; e.n = 0; e.v = 0; e.err = 0;
        e.lat = 2; e.acc = 0;
        case (op)
            0: begin
                r = a + b; e.out = r % M; e.c = int'(r >= M);
                r = sgn(a) + sgn(b); e.v = int'(r >= M / 2 || r < -(M / 2));
            end
            1: begin
                r = a - b; e.out = (r + M) % M; e.c = int'(a >= b);
                r = sgn(a) - sgn(b); e.v = int'(r >= M / 2 || r < -(M / 2));
            end
            2: e.out = a & b;
            3: e.out = a | b;
            4: e.out = a ^ b;
            5: begin e.out = (a * 2) % M; e.c = int'(a >= M / 2); end
            6: begin e.out = a / 2; e.c = int'(a % 2); end
            default: begin
                if (MUL_EN) begin
                    r = a * b; e.out = r % M; e.hi = r / M; e.c = int'(e.hi != 0); e.lat = W + 2;
                end else begin
                    e.err = 1;
                end
            end
        endcase
        if (op == 7) e.z = MUL_EN ? int'(a * b == 0) : 0;
        else         e.z = int'(e.out == 0);
        e.n = int'(e.out >= M / 2);
        return e;
    endfunction

    task automatic issue(int op, longint a, longint b);
        int   t = 0;
        exp_t e;
        while (bus.Busy === 1'b1 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) fail("busy_timeout");
        bus.Start = 1'b1;
        bus.Op    = op[2:0];
        bus.A     = a[W-1:0];
        bus.B     = b[W-1:0];
        @(posedge clk);
        #1;
        e = model(op, a, b);
        e.acc = cyc;
        sb.push_back(e);
        issued++;
        chk("busy_after_start", {63'd0, bus.Busy}, 64'd1);
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    // Start pulses with fresh operands while busy: must be dropped and must not disturb the result.
    task automatic spur();
        int n = 0;
        while (bus.Busy === 1'b1 && n < 4) begin
            bus.Start = 1'b1;
            bus.Op    = 3'($urandom_range(0, 7));
            bus.A     = W'($urandom);
            bus.B     = W'($urandom);
            @(negedge clk);
            bus.Start = 1'b0;
            n++;
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.Done === 1'b1) begin
            if (sb.size() == 0) begin
                fail("unexpected_done");
            end else begin
                me = sb.pop_front();
                popped++;
                last_out = me.out;
                chk($sformatf("op%0d_out", me.op),   64'(bus.ALU_Out),   64'(me.out));
                chk($sformatf("op%0d_hi", me.op),    64'(bus.ALU_OutHi), 64'(me.hi));
                chk($sformatf("op%0d_carry", me.op), 64'(bus.CarryOut),  64'(me.c));
                chk($sformatf("op%0d_zero", me.op),  64'(bus.Zero),      64'(me.z));
                chk($sformatf("op%0d_neg", me.op),   64'(bus.Negative),  64'(me.n));
                chk($sformatf("op%0d_ovf", me.op),   64'(bus.Overflow),  64'(me.v));
                chk($sformatf("op%0d_operr", me.op), 64'(bus.OpErr),     64'(me.err));
                chk($sformatf("op%0d_latency", me.op), 64'(cyc - me.acc + 1), 64'(me.lat));
                chk("busy_at_done", 64'(bus.Busy), 64'd0);
            end
        end
    end

    initial begin
        int t;
        bus.Start = 1'b0; bus.Op = 3'd0; bus.A = '0; bus.B = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 64'({bus.Busy, bus.Done, bus.ALU_Out, bus.ALU_OutHi, bus.CarryOut,
                                bus.Zero, bus.Negative, bus.Overflow, bus.OpErr}), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        issue(0, 'h0C, 'h02);
        issue(0, 'hFF, 'h01);
        issue(1, 'h0C, 'h02);
        spur();
        issue(1, 'h80, 'h01);
        issue(1, 'h01, 'h02);
        issue(5, 'h81, 'h00);
        issue(6, 'h81, 'h00);
        issue(4, 'hAA, 'hAA);
        issue(7, 'hFF, 'hFF);
        spur();
        issue(7, 'h03, 'h05);
        issue(0, 'h11, 'h22);
        repeat (4) @(negedge clk);
        chk("hold_out", 64'(bus.ALU_Out), 64'(last_out));
        chk("done_idle", 64'(bus.Done), 64'd0);

        // Abort: 4th MUL cycle with the multiplier, otherwise during EXEC.
        if (MUL_EN) begin
            issue(7, 'hFF, 'hFF);
            repeat (3) @(negedge clk);
        end else begin
            issue(0, 'h05, 'h06);
        end
        reset = 1'b1;
        bus.Start = 1'b1;
        aborted += sb.size();
        sb.delete();
        @(negedge clk);
        chk("abort_clear", 64'({bus.Busy, bus.Done, bus.ALU_Out, bus.ALU_OutHi, bus.CarryOut,
                                bus.Zero, bus.Negative, bus.Overflow, bus.OpErr}), 64'd0);
        reset = 1'b0;
        bus.Start = 1'b0;
        issue(0, 'h0C, 'h02);

        for (int i = 0; i < 150; i++) begin
            issue(int'($urandom_range(0, 7)), longint'($urandom_range(0, 255)),
                  longint'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) spur();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        t = 0;
        while (sb.size() != 0 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) fail("drain_timeout");
        repeat (3) @(negedge clk);
        chk("done_count", 64'(popped), 64'(issued - aborted));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
